m_lsu: RTL and testbench

Memory-stage load/store initiator for the pipelined CPU. It takes the M-stage access (address, store data, width, sign), checks alignment, and drives a single-outstanding req/ack word bus toward the data memory. It generates byte enables and lane-replicated store data, stalls the pipeline until the responder acknowledges, then returns the lane-selected, sign- or zero-extended load result.

---
 rtl/m_lsu_if.sv | 31 +++
 rtl/m_lsu.sv | 151 +++++++++++++++
 tb/tb_m_lsu.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_lsu_if.sv
// m_lsu_if: single-outstanding req/ack word bus toward data memory.
// The initiator drives the request side; the responder drives ack and rdata.
interface m_lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_byteen,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_byteen,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/m_lsu.sv
// m_lsu: memory-stage load/store initiator.
// Checks alignment, runs one bus transaction per access and extends loads.
module m_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic [31:0] MemAddr_M,
    input  logic [31:0] WDM_M,
    input  logic [1:0]  BitWidth_M,
    input  logic        LoadSign_M,
    input  logic        Hold_M,
    output logic        Stall_M,
    output logic [31:0] RD_M,
    output logic        ExcAdEL_M,
    output logic        ExcAdES_M,
    m_lsu_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    state_t      state;
    logic [1:0]  lane_q;
    logic [1:0]  width_q;
    logic        sign_q;

    logic        access;
    logic        misalign;
    logic        legal;
    logic [3:0]  byteen_d;
    logic [31:0] wdata_d;
    logic [31:0] ext_d;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Access classification and address-error flags
    always_comb begin
        access   = MemRead_M | MemWrite_M;
        misalign = 1'b0;
        unique case (1'b1)
            BitWidth_M == W_WORD: misalign = |MemAddr_M[1:0];
            BitWidth_M == W_HALF: misalign = MemAddr_M[0];
            BitWidth_M == W_BYTE: misalign = 1'b0;
            default:              misalign = 1'b1;
        endcase
        legal     = access & ~misalign;
        ExcAdES_M = access & misalign & MemWrite_M;
        ExcAdEL_M = access & misalign & ~MemWrite_M;
        Stall_M   = ((state == S_IDLE) & legal) | (state == S_REQ);
    end

    // Byte enables and lane-replicated store data for the new access
    always_comb begin
        byteen_d = 4'b0000;
        wdata_d  = WDM_M;
        unique case (1'b1)
            BitWidth_M == W_HALF: begin
                byteen_d = MemAddr_M[1] ? 4'b1100 : 4'b0011;
                wdata_d  = {2{WDM_M[15:0]}};
            end
            BitWidth_M == W_BYTE: begin
                byteen_d = 4'b0001 << MemAddr_M[1:0];
                wdata_d  = {4{WDM_M[7:0]}};
            end
            default: begin
                byteen_d = 4'b1111;
                wdata_d  = WDM_M;
            end
        endcase
    end

    // Lane select and extension of the returned read word
    always_comb begin
        half_sel = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        byte_sel = bus.bus_rdata[7:0];
        unique case (lane_q)
            2'd1:    byte_sel = bus.bus_rdata[15:8];
            2'd2:    byte_sel = bus.bus_rdata[23:16];
            2'd3:    byte_sel = bus.bus_rdata[31:24];
            default: byte_sel = bus.bus_rdata[7:0];
        endcase
        ext_d = bus.bus_rdata;
        unique case (1'b1)
            width_q == W_HALF:
                ext_d = {{16{sign_q & half_sel[15]}}, half_sel};
            width_q == W_BYTE:
                ext_d = {{24{sign_q & byte_sel[7]}}, byte_sel};
            default:
                ext_d = bus.bus_rdata;
        endcase
    end

    // Transaction FSM with registered bus outputs and load result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            bus.bus_req    <= 1'b0;
            bus.bus_we     <= 1'b0;
            bus.bus_addr   <= 32'h0;
            bus.bus_byteen <= 4'b0000;
            bus.bus_wdata  <= 32'h0;
            lane_q         <= 2'b00;
            width_q        <= 2'b00;
            sign_q         <= 1'b0;
            RD_M           <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (legal) begin
                        state          <= S_REQ;
                        bus.bus_req    <= 1'b1;
                        bus.bus_we     <= MemWrite_M;
                        bus.bus_addr   <= {MemAddr_M[31:2], 2'b00};
                        bus.bus_byteen <= byteen_d;
                        bus.bus_wdata  <= wdata_d;
                        lane_q         <= MemAddr_M[1:0];
                        width_q        <= BitWidth_M;
                        sign_q         <= LoadSign_M;
                    end
                end
                S_REQ: begin
                    if (bus.bus_ack) begin
                        state       <= S_DONE;
                        bus.bus_req <= 1'b0;
                        if (!bus.bus_we) begin
                            RD_M <= ext_d;
                        end
                    end
                end
                S_DONE: begin
                    if (!Hold_M) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    bus.bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed checks of the memory-stage load/store initiator.
// Inputs change on the falling edge; outputs are checked just after it.
module tb_m_lsu;

    logic        clk;
    logic        reset;
    logic        MemRead_M;
    logic        MemWrite_M;
    logic [31:0] MemAddr_M;
    logic [31:0] WDM_M;
    logic [1:0]  BitWidth_M;
    logic        LoadSign_M;
    logic        Hold_M;
    logic        Stall_M;
    logic [31:0] RD_M;
    logic        ExcAdEL_M;
    logic        ExcAdES_M;

    int errors = 0;
    int checks = 0;

    m_lsu_if bus ();

    m_lsu dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead_M  (MemRead_M),
        .MemWrite_M (MemWrite_M),
        .MemAddr_M  (MemAddr_M),
        .WDM_M      (WDM_M),
        .BitWidth_M (BitWidth_M),
        .LoadSign_M (LoadSign_M),
        .Hold_M     (Hold_M),
        .Stall_M    (Stall_M),
        .RD_M       (RD_M),
        .ExcAdEL_M  (ExcAdEL_M),
        .ExcAdES_M  (ExcAdES_M),
        .bus        (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_in();
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b0;
        MemAddr_M  = 32'h0;
        WDM_M      = 32'h0;
        BitWidth_M = 2'b00;
        LoadSign_M = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] w,
                        input logic s);
        MemRead_M  = 1'b1;
        MemWrite_M = 1'b0;
        MemAddr_M  = a;
        BitWidth_M = w;
        LoadSign_M = s;
    endtask

    // One transaction with ack on the first REQ cycle; ends in DONE
    task automatic ack_now(input logic [31:0] rd);
        step();
        chk("req_up", {31'b0, bus.bus_req}, 32'd1);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = rd;
        step();
        bus.bus_ack = 1'b0;
    endtask

    logic [31:0] a0;
    logic [3:0]  be0;

    initial begin
        reset         = 1'b1;
        Hold_M        = 1'b0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0;
        idle_in();
        step();
        chk("rst_req", {31'b0, bus.bus_req}, 32'd0);
        chk("rst_we", {31'b0, bus.bus_we}, 32'd0);
        chk("rst_addr", bus.bus_addr, 32'h0);
        chk("rst_be", {28'b0, bus.bus_byteen}, 32'h0);
        chk("rst_wd", bus.bus_wdata, 32'h0);
        chk("rst_rd", RD_M, 32'h0);
        chk("rst_stall", {31'b0, Stall_M}, 32'd0);
        reset = 1'b0;
        step();

        // lw 0x10, ack on first REQ cycle
        load(32'h10, 2'b00, 1'b0);
        #1;
        chk("lw_stall0", {31'b0, Stall_M}, 32'd1);
        chk("lw_noreq0", {31'b0, bus.bus_req}, 32'd0);
        step();
        chk("lw_stall1", {31'b0, Stall_M}, 32'd1);
        chk("lw_addr", bus.bus_addr, 32'h10);
        chk("lw_be", {28'b0, bus.bus_byteen}, 32'hF);
        chk("lw_we", {31'b0, bus.bus_we}, 32'd0);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h8765_4321;
        step();
        bus.bus_ack = 1'b0;
        chk("lw_done_stall", {31'b0, Stall_M}, 32'd0);
        chk("lw_done_req", {31'b0, bus.bus_req}, 32'd0);
        chk("lw_rd", RD_M, 32'h8765_4321);
        idle_in();
        step();
        chk("lw_idle_stall", {31'b0, Stall_M}, 32'd0);

        // sb 0xA5 at 0x3
        MemWrite_M = 1'b1;
        MemAddr_M  = 32'h3;
        WDM_M      = 32'h0000_00A5;
        BitWidth_M = 2'b10;
        #1;
        chk("sb_stall0", {31'b0, Stall_M}, 32'd1);
        step();
        chk("sb_be", {28'b0, bus.bus_byteen}, 32'h8);
        chk("sb_wd", bus.bus_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'b0, bus.bus_we}, 32'd1);
        chk("sb_addr", bus.bus_addr, 32'h0);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hDEAD_BEEF;
        step();
        bus.bus_ack = 1'b0;
        chk("sb_done_stall", {31'b0, Stall_M}, 32'd0);
        chk("sb_rd_keep", RD_M, 32'h8765_4321);
        idle_in();
        step();

        // sh replicates the low half into both lanes
        MemWrite_M = 1'b1;
        MemAddr_M  = 32'h6;
        WDM_M      = 32'h1234_BEEF;
        BitWidth_M = 2'b01;
        step();
        chk("sh_be", {28'b0, bus.bus_byteen}, 32'hC);
        chk("sh_wd", bus.bus_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", bus.bus_addr, 32'h4);
        bus.bus_ack = 1'b1;
        step();
        bus.bus_ack = 1'b0;
        idle_in();
        step();

        // lb signed / unsigned at lane 2
        load(32'h0000_1002, 2'b10, 1'b1);
        step();
        chk("lbs_be", {28'b0, bus.bus_byteen}, 32'h4);
        chk("lbs_addr", bus.bus_addr, 32'h1000);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h0080_FF00;
        step();
        bus.bus_ack = 1'b0;
        chk("lbs_rd", RD_M, 32'hFFFF_FF80);
        idle_in();
        step();
        load(32'h0000_1002, 2'b10, 1'b0);
        ack_now(32'h0080_FF00);
        chk("lbu_rd", RD_M, 32'h0000_0080);
        idle_in();
        step();

        // lb lane 1 signed picks bits 15:8
        load(32'h0000_2001, 2'b10, 1'b1);
        ack_now(32'h0080_FF00);
        chk("lb1_rd", RD_M, 32'hFFFF_FFFF);
        idle_in();
        step();

        // lh signed at 0x2
        load(32'h0000_3002, 2'b01, 1'b1);
        step();
        chk("lh_be", {28'b0, bus.bus_byteen}, 32'hC);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h8001_1234;
        step();
        bus.bus_ack = 1'b0;
        chk("lh_rd", RD_M, 32'hFFFF_8001);
        idle_in();
        step();

        // lhu at 0x0 takes the low half zero-filled
        load(32'h0000_3000, 2'b01, 1'b0);
        ack_now(32'hFFFF_9ABC);
        chk("lhu_rd", RD_M, 32'h0000_9ABC);
        idle_in();
        step();

        // Misaligned and illegal-width accesses
        load(32'h0000_3001, 2'b01, 1'b1);
        #1;
        chk("lh_mis_el", {31'b0, ExcAdEL_M}, 32'd1);
        chk("lh_mis_es", {31'b0, ExcAdES_M}, 32'd0);
        chk("lh_mis_stall", {31'b0, Stall_M}, 32'd0);
        step();
        chk("lh_mis_noreq", {31'b0, bus.bus_req}, 32'd0);
        chk("lh_mis_rd", RD_M, 32'h0000_9ABC);
        MemRead_M  = 1'b0;
        MemWrite_M = 1'b1;
        MemAddr_M  = 32'h0000_0042;
        BitWidth_M = 2'b00;
        #1;
        chk("sw_mis_es", {31'b0, ExcAdES_M}, 32'd1);
        chk("sw_mis_el", {31'b0, ExcAdEL_M}, 32'd0);
        chk("sw_mis_stall", {31'b0, Stall_M}, 32'd0);
        step();
        chk("sw_mis_noreq", {31'b0, bus.bus_req}, 32'd0);
        MemAddr_M  = 32'h0000_0040;
        BitWidth_M = 2'b11;
        #1;
        chk("w11_es", {31'b0, ExcAdES_M}, 32'd1);
        chk("w11_stall", {31'b0, Stall_M}, 32'd0);
        idle_in();
        #1;
        chk("noacc_el", {31'b0, ExcAdEL_M}, 32'd0);
        step();

        // Stray ack while idle is ignored
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h5555_5555;
        step();
        bus.bus_ack = 1'b0;
        chk("stray_req", {31'b0, bus.bus_req}, 32'd0);
        chk("stray_rd", RD_M, 32'h0000_9ABC);

        // lw with ack on the 5th REQ cycle, then Hold for 2 DONE cycles
        load(32'h0000_0020, 2'b00, 1'b0);
        step();
        a0  = bus.bus_addr;
        be0 = bus.bus_byteen;
        chk("dly_addr", a0, 32'h20);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dly_req", {31'b0, bus.bus_req}, 32'd1);
            chk("dly_stall", {31'b0, Stall_M}, 32'd1);
            chk("dly_addr_hold", bus.bus_addr, 32'h20);
            chk("dly_be_hold", {28'b0, bus.bus_byteen}, 32'hF);
        end
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hCAFE_F00D;
        Hold_M        = 1'b1;
        step();
        bus.bus_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("hold_stall", {31'b0, Stall_M}, 32'd0);
            chk("hold_req", {31'b0, bus.bus_req}, 32'd0);
            chk("hold_rd", RD_M, 32'hCAFE_F00D);
            if (i == 1) begin
                Hold_M = 1'b0;
                idle_in();
            end
            step();
        end
        chk("hold_exit_req", {31'b0, bus.bus_req}, 32'd0);
        chk("hold_exit_stall", {31'b0, Stall_M}, 32'd0);
        step();
        chk("hold_no2nd", {31'b0, bus.bus_req}, 32'd0);

        // Reset in the middle of a request
        load(32'h0000_0044, 2'b00, 1'b0);
        step();
        chk("rr_req", {31'b0, bus.bus_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_req0", {31'b0, bus.bus_req}, 32'd0);
        chk("rr_addr0", bus.bus_addr, 32'h0);
        chk("rr_be0", {28'b0, bus.bus_byteen}, 32'h0);
        chk("rr_rd0", RD_M, 32'h0);
        idle_in();
        step();
        reset = 1'b0;
        step();
        chk("rr_idle_req", {31'b0, bus.bus_req}, 32'd0);
        load(32'h0000_0048, 2'b00, 1'b0);
        step();
        chk("rr_lw_addr", bus.bus_addr, 32'h48);
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h0BAD_CAFE;
        step();
        bus.bus_ack = 1'b0;
        chk("rr_lw_rd", RD_M, 32'h0BAD_CAFE);
        chk("rr_lw_stall", {31'b0, Stall_M}, 32'd0);
        idle_in();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
